// File: rtl/tx_resp_packer.sv
// Response packer: captures an ALU result (two bytes, LSB first) or a register
// read (one byte) and paces them onto the UART TX path using TX_Busy.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a new response; PK_READY=1
// LOAD    | drive the next byte onto TX_P_DATA and raise TX_DATA_VALID
// WAIT_HI | hold TX_DATA_VALID until TX_Busy rises (bounded by timeout)
// WAIT_LO | TX is sending the byte; wait for TX_Busy to fall
module tx_resp_packer #(
   parameter int DATA_WIDTH    = 8,
   parameter int ALU_OUT_WIDTH = 16,
   parameter int TIMEOUT_WIDTH = 8,
   parameter int BUSY_TIMEOUT  = 200
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
   input  logic                     ALU_OUT_VALID,
   input  logic [DATA_WIDTH-1:0]    RdData,
   input  logic                     RdData_Valid,
   input  logic                     TX_Busy,
   output logic [DATA_WIDTH-1:0]    TX_P_DATA,
   output logic                     TX_DATA_VALID,
   output logic                     PK_READY,
   output logic                     PK_DROP,
   output logic                     PK_TIMEOUT
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   localparam logic [TIMEOUT_WIDTH-1:0] TERM_CNT = TIMEOUT_WIDTH'(BUSY_TIMEOUT - 1);

   state_t                   state;
   logic [ALU_OUT_WIDTH-1:0] data_buf;
   logic                     two_byte;
   logic                     msb_sel;
   logic [TIMEOUT_WIDTH-1:0] busy_cnt;
   logic                     any_valid;

   assign any_valid = ALU_OUT_VALID | RdData_Valid;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state         <= IDLE;
         data_buf      <= '0;
         two_byte      <= 1'b0;
         msb_sel       <= 1'b0;
         busy_cnt      <= '0;
         TX_P_DATA     <= '0;
         TX_DATA_VALID <= 1'b0;
         PK_READY      <= 1'b1;
         PK_DROP       <= 1'b0;
         PK_TIMEOUT    <= 1'b0;
      end else begin
         PK_DROP    <= 1'b0;
         PK_TIMEOUT <= 1'b0;
         case (state)
            IDLE: begin
               // ALU wins a same-cycle collision; the read is reported as dropped
               PK_DROP <= ALU_OUT_VALID & RdData_Valid;
               if (ALU_OUT_VALID) begin
                  data_buf <= ALU_OUT;
                  two_byte <= 1'b1;
                  msb_sel  <= 1'b0;
                  PK_READY <= 1'b0;
                  state    <= LOAD;
               end else if (RdData_Valid) begin
                  data_buf <= ALU_OUT_WIDTH'(RdData);
                  two_byte <= 1'b0;
                  msb_sel  <= 1'b0;
                  PK_READY <= 1'b0;
                  state    <= LOAD;
               end
            end

            LOAD: begin
               PK_DROP       <= any_valid;
               TX_P_DATA     <= msb_sel ? data_buf[ALU_OUT_WIDTH-1:DATA_WIDTH]
                                        : data_buf[DATA_WIDTH-1:0];
               TX_DATA_VALID <= 1'b1;
               busy_cnt      <= '0;
               state         <= WAIT_HI;
            end

            WAIT_HI: begin
               PK_DROP <= any_valid;
               if (TX_Busy) begin
                  TX_DATA_VALID <= 1'b0;
                  state         <= WAIT_LO;
               end else if (busy_cnt == TERM_CNT) begin
                  // lost handshake: abort the whole frame, pending MSB included
                  TX_DATA_VALID <= 1'b0;
                  PK_TIMEOUT    <= 1'b1;
                  two_byte      <= 1'b0;
                  PK_READY      <= 1'b1;
                  state         <= IDLE;
               end else begin
                  busy_cnt <= busy_cnt + TIMEOUT_WIDTH'(1);
               end
            end

            WAIT_LO: begin
               PK_DROP <= any_valid;
               if (!TX_Busy) begin
                  if (two_byte && !msb_sel) begin
                     msb_sel <= 1'b1;
                     state   <= LOAD;
                  end else begin
                     PK_READY <= 1'b1;
                     state    <= IDLE;
                  end
               end
            end

            default: begin
               TX_DATA_VALID <= 1'b0;
               PK_READY      <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tx_resp_packer.sv
// Directed bench for tx_resp_packer: byte order, pacing, drops, timeout and
// mid-frame reset, with hand-computed expectations.
module tb_tx_resp_packer;

   localparam int BUSY_TIMEOUT = 200;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] ALU_OUT;
   logic        ALU_OUT_VALID;
   logic [7:0]  RdData;
   logic        RdData_Valid;
   logic        TX_Busy;
   logic [7:0]  TX_P_DATA;
   logic        TX_DATA_VALID;
   logic        PK_READY;
   logic        PK_DROP;
   logic        PK_TIMEOUT;

   int checks = 0;
   int errors = 0;

   logic [7:0] sent[$];
   int         drop_cnt = 0;
   int         to_cnt = 0;
   logic       prev_v = 1'b0;

   tx_resp_packer #(
      .DATA_WIDTH(8), .ALU_OUT_WIDTH(16), .TIMEOUT_WIDTH(8), .BUSY_TIMEOUT(BUSY_TIMEOUT)
   ) dut (
      .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
      .RdData(RdData), .RdData_Valid(RdData_Valid), .TX_Busy(TX_Busy),
      .TX_P_DATA(TX_P_DATA), .TX_DATA_VALID(TX_DATA_VALID), .PK_READY(PK_READY),
      .PK_DROP(PK_DROP), .PK_TIMEOUT(PK_TIMEOUT)
   );

   always #5 CLK = ~CLK;

   // records every presented byte and counts the status pulses
   always @(negedge CLK) begin
      if (TX_DATA_VALID === 1'b1 && prev_v !== 1'b1) sent.push_back(TX_P_DATA);
      prev_v = TX_DATA_VALID;
      if (PK_DROP === 1'b1) drop_cnt++;
      if (PK_TIMEOUT === 1'b1) to_cnt++;
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_alu(input logic [15:0] v);
      ALU_OUT = v; ALU_OUT_VALID = 1'b1;
      tick;
      ALU_OUT_VALID = 1'b0;
   endtask

   task automatic pulse_rd(input logic [7:0] v);
      RdData = v; RdData_Valid = 1'b1;
      tick;
      RdData_Valid = 1'b0;
   endtask

   // acts as the TX side for one byte: waits for valid, acks after dly cycles,
   // keeps busy high for hi cycles, optionally pokes RdData_Valid during WAIT_LO
   task automatic xfer(input int dly, input int hi, input bit inj,
                       output logic [7:0] b, output bit ok, output bit stable, output bit vdrop);
      ok = 1'b0; stable = 1'b1; vdrop = 1'b0; b = 8'h00;
      for (int i = 0; i < 50; i++) begin
         if (TX_DATA_VALID === 1'b1) begin ok = 1'b1; break; end
         tick;
      end
      if (!ok) return;
      b = TX_P_DATA;
      for (int i = 1; i < dly; i++) begin
         tick;
         if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== b) stable = 1'b0;
      end
      TX_Busy = 1'b1;
      tick;
      vdrop = (TX_DATA_VALID === 1'b0);
      for (int i = 0; i < hi - 1; i++) begin
         if (inj && i == 2) begin RdData = 8'hEE; RdData_Valid = 1'b1; end
         tick;
         RdData_Valid = 1'b0;
         if (TX_P_DATA !== b || TX_DATA_VALID !== 1'b0) stable = 1'b0;
      end
      TX_Busy = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (PK_READY === 1'b1) begin ok = 1'b1; break; end
         tick;
      end
   endtask

   task automatic test_reset;
      RST = 1'b0;
      repeat (2) tick;
      checks++; if (TX_P_DATA !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", TX_P_DATA); end
      checks++; if (TX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", TX_DATA_VALID); end
      checks++; if (PK_READY !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", PK_READY); end
      checks++; if (PK_DROP !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", PK_DROP); end
      checks++; if (PK_TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", PK_TIMEOUT); end
      RST = 1'b1;
      repeat (2) tick;
      checks++; if (PK_READY !== 1'b1 || TX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL post_reset_idle: ready %b valid %b want 1 0", PK_READY, TX_DATA_VALID); end
   endtask

   task automatic test_alu_two_byte;
      logic [7:0] b; bit ok, st, vd, rdy; int d0;
      sent.delete(); d0 = drop_cnt;
      pulse_alu(16'hA55A);
      checks++; if (PK_READY !== 1'b0) begin errors++; $display("FAIL alu_ready_low: got %b want 0", PK_READY); end
      checks++; if (TX_DATA_VALID !== 1'b0) begin errors++; $display("FAIL alu_load_valid: got %b want 0", TX_DATA_VALID); end
      tick;
      checks++; if (TX_DATA_VALID !== 1'b1 || TX_P_DATA !== 8'h5A) begin errors++; $display("FAIL alu_first_out: valid %b data %h want 1 5a", TX_DATA_VALID, TX_P_DATA); end
      xfer(4, 20, 1'b0, b, ok, st, vd);
      checks++; if (!ok || b !== 8'h5A) begin errors++; $display("FAIL alu_lsb: got %h ok %b want 5a", b, ok); end
      checks++; if (!st || !vd) begin errors++; $display("FAIL alu_lsb_hold: stable %b valid_drop %b want 1 1", st, vd); end
      xfer(4, 20, 1'b0, b, ok, st, vd);
      checks++; if (!ok || b !== 8'hA5) begin errors++; $display("FAIL alu_msb: got %h ok %b want a5", b, ok); end
      checks++; if (!st || !vd) begin errors++; $display("FAIL alu_msb_hold: stable %b valid_drop %b want 1 1", st, vd); end
      wait_idle(rdy);
      checks++; if (!rdy) begin errors++; $display("FAIL alu_idle: ready never returned"); end
      checks++; if (sent.size() != 2 || sent[0] !== 8'h5A || sent[1] !== 8'hA5 || drop_cnt != d0)
         begin errors++; $display("FAIL alu_seq: %0d bytes, drops %0d, want 5a a5 with 0 drops", sent.size(), drop_cnt - d0); end
   endtask

   task automatic test_rd_single;
      logic [7:0] b; bit ok, st, vd;
      sent.delete();
      pulse_rd(8'h3C);
      xfer(3, 5, 1'b0, b, ok, st, vd);
      checks++; if (!ok || b !== 8'h3C || !st || !vd) begin errors++; $display("FAIL rd_byte: got %h ok %b stable %b want 3c", b, ok, st); end
      checks++; if (PK_READY !== 1'b0) begin errors++; $display("FAIL rd_ready_early: got %b want 0", PK_READY); end
      tick;
      checks++; if (PK_READY !== 1'b1) begin errors++; $display("FAIL rd_ready_back: got %b want 1", PK_READY); end
      repeat (5) tick;
      checks++; if (TX_DATA_VALID !== 1'b0 || TX_P_DATA !== 8'h3C || sent.size() != 1)
         begin errors++; $display("FAIL rd_single: valid %b data %h bytes %0d want 0 3c 1", TX_DATA_VALID, TX_P_DATA, sent.size()); end
   endtask

   task automatic test_both_valid;
      logic [7:0] b0, b1; bit ok0, ok1, st, vd, rdy; int d0;
      sent.delete(); d0 = drop_cnt;
      ALU_OUT = 16'h1234; RdData = 8'hFF;
      ALU_OUT_VALID = 1'b1; RdData_Valid = 1'b1;
      tick;
      ALU_OUT_VALID = 1'b0; RdData_Valid = 1'b0;
      xfer(2, 6, 1'b0, b0, ok0, st, vd);
      xfer(2, 6, 1'b0, b1, ok1, st, vd);
      wait_idle(rdy);
      repeat (3) tick;
      checks++; if (!ok0 || !ok1 || b0 !== 8'h34 || b1 !== 8'h12) begin errors++; $display("FAIL both_bytes: got %h %h want 34 12", b0, b1); end
      checks++; if (drop_cnt - d0 != 1) begin errors++; $display("FAIL both_drop: got %0d pulses want 1", drop_cnt - d0); end
      checks++; if (sent.size() != 2) begin errors++; $display("FAIL both_no_ff: got %0d bytes want 2", sent.size()); end
   endtask

   task automatic test_drop_wait_lo;
      logic [7:0] b; bit ok, st, vd, rdy; int d0;
      sent.delete(); d0 = drop_cnt;
      pulse_alu(16'hBEEF);
      xfer(3, 8, 1'b1, b, ok, st, vd);
      checks++; if (!ok || b !== 8'hEF || !st) begin errors++; $display("FAIL waitlo_lsb: got %h stable %b want ef 1", b, st); end
      checks++; if (drop_cnt - d0 != 1) begin errors++; $display("FAIL waitlo_drop: got %0d pulses want 1", drop_cnt - d0); end
      xfer(3, 8, 1'b0, b, ok, st, vd);
      checks++; if (!ok || b !== 8'hBE) begin errors++; $display("FAIL waitlo_msb: got %h want be", b); end
      wait_idle(rdy);
      checks++; if (!rdy || sent.size() != 2) begin errors++; $display("FAIL waitlo_done: ready %b bytes %0d want 1 2", rdy, sent.size()); end
   endtask

   task automatic test_timeout;
      int n; int t0;
      sent.delete(); t0 = to_cnt;
      TX_Busy = 1'b0;
      pulse_alu(16'hC0DE);
      n = 0;
      while (PK_TIMEOUT !== 1'b1 && n < 400) begin
         tick;
         n++;
      end
      checks++; if (n != BUSY_TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency: got %0d cycles want %0d", n, BUSY_TIMEOUT + 1); end
      checks++; if (TX_DATA_VALID !== 1'b0 || PK_READY !== 1'b1) begin errors++; $display("FAIL timeout_state: valid %b ready %b want 0 1", TX_DATA_VALID, PK_READY); end
      tick;
      checks++; if (PK_TIMEOUT !== 1'b0) begin errors++; $display("FAIL timeout_pulse: got %b want 0", PK_TIMEOUT); end
      repeat (5) tick;
      checks++; if (sent.size() != 1 || sent[0] !== 8'hDE || to_cnt - t0 != 1)
         begin errors++; $display("FAIL timeout_no_msb: bytes %0d pulses %0d want 1 byte de, 1 pulse", sent.size(), to_cnt - t0); end
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] b; bit ok, st, vd, found, rdy;
      pulse_alu(16'h5678);
      xfer(2, 4, 1'b0, b, ok, st, vd);
      checks++; if (!ok || b !== 8'h78) begin errors++; $display("FAIL rstmid_lsb: got %h want 78", b); end
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (TX_DATA_VALID === 1'b1) begin found = 1'b1; break; end
         tick;
      end
      checks++; if (!found || TX_P_DATA !== 8'h56) begin errors++; $display("FAIL rstmid_msb_load: found %b data %h want 1 56", found, TX_P_DATA); end
      RST = 1'b0;
      tick;
      RST = 1'b1;
      checks++; if (TX_DATA_VALID !== 1'b0 || TX_P_DATA !== 8'h00 || PK_READY !== 1'b1 || PK_DROP !== 1'b0 || PK_TIMEOUT !== 1'b0)
         begin errors++; $display("FAIL rstmid_outputs: valid %b data %h ready %b drop %b to %b want 0 00 1 0 0",
                                  TX_DATA_VALID, TX_P_DATA, PK_READY, PK_DROP, PK_TIMEOUT); end
      repeat (6) tick;
      checks++; if (TX_DATA_VALID !== 1'b0 || PK_READY !== 1'b1) begin errors++; $display("FAIL rstmid_no_resume: valid %b ready %b want 0 1", TX_DATA_VALID, PK_READY); end
      sent.delete();
      pulse_rd(8'h81);
      xfer(2, 4, 1'b0, b, ok, st, vd);
      wait_idle(rdy);
      repeat (4) tick;
      checks++; if (!ok || b !== 8'h81 || !rdy || sent.size() != 1)
         begin errors++; $display("FAIL rstmid_new_rd: got %h ready %b bytes %0d want 81 1 1", b, rdy, sent.size()); end
   endtask

   initial begin
      RST = 1'b0; ALU_OUT = '0; ALU_OUT_VALID = 1'b0;
      RdData = '0; RdData_Valid = 1'b0; TX_Busy = 1'b0;
      test_reset;
      test_alu_two_byte;
      test_rd_single;
      test_both_valid;
      test_drop_wait_lo;
      test_timeout;
      test_reset_mid_frame;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
